// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer.
//   STATE_W : width of the sequencer state register
//   state_e : sequencer states (IDLE=0, RUN=1, PAUSED=2, DONE=3)
package counter_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/counter_sequencer_step_prescaler.sv
// Modulo-DIV prescaler that paces the count steps.
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   clear  : return the prescaler to 0 (takes priority over enable)
//   enable : advance the prescaler this cycle
//   step   : high when enable=1 and the prescaler sits at DIV-1
module step_prescaler #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic step
);

    // DIV=1 still needs a one-bit register; it simply never leaves 0.
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign step = enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = step ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop/pause sequencer around a WIDTH-bit up/down counter with a
// programmable terminal value, one-shot or continuous mode and a prescaled
// step rate. All outputs are registered.
//   clock, reset : system clock, synchronous active-high reset
//   start        : (re)start a sequence; latches limit, down, oneshot
//   stop         : abort to IDLE (beats start)
//   pause        : freeze the count while running
//   oneshot      : 1 = halt in DONE at terminal, 0 = wrap and continue
//   down         : 1 = count down from limit, 0 = count up to limit
//   limit        : terminal value
//   count        : current count
//   running/paused/done : state flags
//   wrap         : one-cycle pulse when a continuous sequence reloads
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             oneshot,
    input  logic             down,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             wrap
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             down_q, down_d;
    logic             oneshot_q, oneshot_d;
    logic             running_q, running_d;
    logic             paused_q, paused_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    logic pre_clear, pre_enable, step, terminal;

    // The prescaler only advances on an undisturbed RUN cycle; stop and
    // start both zero it, pause leaves it holding its value.
    assign pre_clear  = stop | start;
    assign pre_enable = (state_q == ST_RUN) & ~stop & ~start & ~pause;

    step_prescaler #(.DIV(DIV)) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (pre_clear),
        .enable (pre_enable),
        .step   (step)
    );

    // Checking terminal before stepping keeps the arithmetic from ever
    // overflowing or underflowing.
    assign terminal = down_q ? (count_q == '0) : (count_q == limit_q);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        limit_d   = limit_q;
        down_d    = down_q;
        oneshot_d = oneshot_q;
        wrap_d    = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start) begin
            limit_d   = limit;
            down_d    = down;
            oneshot_d = oneshot;
            count_d   = down ? limit : '0;
            state_d   = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (step) begin
                        if (terminal) begin
                            if (oneshot_q) begin
                                state_d = ST_DONE;
                            end else begin
                                count_d = down_q ? limit_q : '0;
                                wrap_d  = 1'b1;
                            end
                        end else begin
                            count_d = down_q ? count_q - WIDTH'(1)
                                             : count_q + WIDTH'(1);
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end

        running_d = (state_d == ST_RUN);
        paused_d  = (state_d == ST_PAUSED);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            limit_q   <= '0;
            down_q    <= 1'b0;
            oneshot_q <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            down_q    <= down_d;
            oneshot_q <= oneshot_d;
            running_q <= running_d;
            paused_q  <= paused_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign paused  = paused_q;
    assign done    = done_q;
    assign wrap    = wrap_q;

endmodule
